rtr_systolic_feeder: RTL and testbench

Edge driver for a row of rtr_systolic_general routers. It sits at the west end of the row and buffers incoming input activations in a FIFO. For each command it streams a framed burst of iact/ctrl beats into the first router and injects a constant psum seed into the psum chain. After a fixed drain latency it captures the psum returning from the far end and presents it on a valid/ready result port.

---
 rtl/rtr_systolic_feeder.sv | 220 ++++++++++++++++++++++
 tb/tb_rtr_systolic_feeder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rtr_systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : rtr_systolic_feeder
//  Purpose  : West-edge driver for a row of rtr_systolic_general routers.
//             Buffers input activations in a FIFO, streams one framed burst
//             of iact/ctrl beats per command into the first router, seeds the
//             psum chain with the command bias, and captures the psum that
//             returns from the far end a fixed drain latency later.
//  Ports    : clk, rst                  - clock, async active-high reset
//             iact_in_*                 - upstream activation stream (v/r)
//             cmd_*                     - command: length, config, bias (v/r)
//             sys_ctrl_out/iact_out     - registered beat into router 0
//             sys_psum_out              - registered psum seed (bias)
//             sys_psum_in               - psum returning from the last router
//             res_data/valid/ready      - captured result (v/r)
//             busy                      - pass in progress
//  Revision : 1.0 - initial release
// ============================================================================
module rtr_systolic_feeder #(
  parameter int I_WIDTH    = 8,
  parameter int P_WIDTH    = 20,
  parameter int CTRL_WIDTH = 9,
  parameter int DEPTH      = 8,
  parameter int LEN_W      = 8,
  parameter int DRAIN_LAT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [I_WIDTH-1:0]    iact_in_data,
  input  logic                  iact_in_valid,
  output logic                  iact_in_ready,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [CTRL_WIDTH-4:0] cmd_cfg,
  input  logic [P_WIDTH-1:0]    cmd_bias,
  output logic [CTRL_WIDTH-1:0] sys_ctrl_out,
  output logic [I_WIDTH-1:0]    sys_iact_out,
  output logic [P_WIDTH-1:0]    sys_psum_out,
  input  logic [P_WIDTH-1:0]    sys_psum_in,
  output logic [P_WIDTH-1:0]    res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy
);

  localparam int c_ADDR_W  = $clog2(DEPTH);
  localparam int c_CFG_W   = CTRL_WIDTH - 3;
  localparam int c_DRAIN_W = $clog2(DRAIN_LAT + 1);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DRAIN_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Activation FIFO: pointers carry one extra wrap bit to tell full from empty
  // --------------------------------------------------------------------------
  logic [I_WIDTH-1:0]  r_mem [DEPTH];
  logic [c_ADDR_W:0]   r_wptr;
  logic [c_ADDR_W:0]   r_rptr;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [I_WIDTH-1:0]  w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_ADDR_W] != r_rptr[c_ADDR_W]) &&
                   (r_wptr[c_ADDR_W-1:0] == r_rptr[c_ADDR_W-1:0]);
  assign w_push  = iact_in_valid && !w_full;
  assign w_head  = r_mem[r_rptr[c_ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[c_ADDR_W-1:0]] <= iact_in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Pass context and datapath registers
  // --------------------------------------------------------------------------
  logic [LEN_W-1:0]      r_len;
  logic [c_CFG_W-1:0]    r_cfg;
  logic [LEN_W-1:0]      r_cnt;
  logic [c_DRAIN_W-1:0]  r_drain;
  logic [CTRL_WIDTH-1:0] r_ctrl;
  logic [I_WIDTH-1:0]    r_iact;
  logic [P_WIDTH-1:0]    r_psum;
  logic [P_WIDTH-1:0]    r_res_data;
  logic                  r_res_valid;

  logic w_accept;
  logic w_capture;
  logic w_release;
  logic w_is_first;
  logic w_is_last;

  assign w_is_first = (r_cnt == '0);
  assign w_is_last  = (r_cnt == (r_len - LEN_W'(1)));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          // A zero-length command skips straight to the drain wait
          w_state_nxt = (cmd_len != '0) ? S_STREAM : S_DRAIN;
        end
      end
      S_STREAM: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_is_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain == c_DRAIN_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len       <= '0;
      r_cfg       <= '0;
      r_cnt       <= '0;
      r_drain     <= '0;
      r_ctrl      <= '0;
      r_iact      <= '0;
      r_psum      <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      // Every cycle without a popped beat drives a bubble
      r_ctrl <= '0;
      r_iact <= '0;

      if (w_accept) begin
        r_len   <= cmd_len;
        r_cfg   <= cmd_cfg;
        r_psum  <= cmd_bias;
        r_cnt   <= '0;
        r_drain <= '0;
      end

      if (w_pop) begin
        r_ctrl <= {r_cfg, w_is_last, w_is_first, 1'b1};
        r_iact <= w_head;
        r_cnt  <= r_cnt + LEN_W'(1);
      end

      // Counter starts at 0 in the cycle after the last beat is on the bus,
      // so reaching DRAIN_LAT-1 lands the capture DRAIN_LAT cycles later
      if ((r_state == S_DRAIN) && !w_capture) begin
        r_drain <= r_drain + c_DRAIN_W'(1);
      end

      if (w_capture) begin
        r_res_data  <= sys_psum_in;
        r_res_valid <= 1'b1;
      end

      if (w_release) begin
        r_res_valid <= 1'b0;
        r_psum      <= '0;
      end
    end
  end

  assign iact_in_ready = !w_full;
  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign sys_ctrl_out  = r_ctrl;
  assign sys_iact_out  = r_iact;
  assign sys_psum_out  = r_psum;
  assign res_data      = r_res_data;
  assign res_valid     = r_res_valid;

endmodule
`default_nettype wire

// File: tb/tb_rtr_systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtr_systolic_feeder
//  Purpose  : Self-checking bench for rtr_systolic_feeder. A queue-based
//             reference model tracks FIFO contents, burst framing, drain
//             timing and the captured result; the psum chain is modelled as
//             sys_psum_in = sys_psum_out + chain_off.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtr_systolic_feeder;

  localparam int I_WIDTH    = 8;
  localparam int P_WIDTH    = 20;
  localparam int CTRL_WIDTH = 9;
  localparam int DEPTH      = 8;
  localparam int LEN_W      = 8;
  localparam int DRAIN_LAT  = 4;
  localparam int CFG_W      = CTRL_WIDTH - 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [I_WIDTH-1:0]    iact_in_data = '0;
  logic                  iact_in_valid = 1'b0;
  logic                  iact_in_ready;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [LEN_W-1:0]      cmd_len = '0;
  logic [CFG_W-1:0]      cmd_cfg = '0;
  logic [P_WIDTH-1:0]    cmd_bias = '0;
  logic [CTRL_WIDTH-1:0] sys_ctrl_out;
  logic [I_WIDTH-1:0]    sys_iact_out;
  logic [P_WIDTH-1:0]    sys_psum_out;
  logic [P_WIDTH-1:0]    sys_psum_in;
  logic [P_WIDTH-1:0]    res_data;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  logic                  busy;

  logic [P_WIDTH-1:0]    chain_off = P_WIDTH'(7);
  bit                    chain_ramp = 1'b0;

  assign sys_psum_in = sys_psum_out + chain_off;

  always #5 clk = ~clk;

  rtr_systolic_feeder #(
    .I_WIDTH(I_WIDTH), .P_WIDTH(P_WIDTH), .CTRL_WIDTH(CTRL_WIDTH),
    .DEPTH(DEPTH), .LEN_W(LEN_W), .DRAIN_LAT(DRAIN_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .iact_in_data(iact_in_data), .iact_in_valid(iact_in_valid),
    .iact_in_ready(iact_in_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_cfg(cmd_cfg), .cmd_bias(cmd_bias),
    .sys_ctrl_out(sys_ctrl_out), .sys_iact_out(sys_iact_out),
    .sys_psum_out(sys_psum_out), .sys_psum_in(sys_psum_in),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state
  logic [I_WIDTH-1:0] m_q[$];
  bit                 m_busy, m_stream, m_drain, m_hold;
  int                 m_len, m_done, m_cap_edge;
  logic [CFG_W-1:0]   m_cfg;
  logic [P_WIDTH-1:0] m_bias, m_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_busy = 0; m_stream = 0; m_drain = 0; m_hold = 0;
    m_done = 0; m_len = 0; m_cap_edge = 0;
  endtask

  // One clock cycle: pre-edge ready checks, edge, model update, output checks
  task automatic step();
    int                    pre  = m_q.size();
    bit                    beat = m_stream && (pre > 0);
    bit                    push = iact_in_valid && (pre < DEPTH);
    bit                    acc  = cmd_valid && !m_busy;
    bit                    rel  = m_hold && res_ready;
    bit                    cap  = m_drain && (cyc + 1 == m_cap_edge);
    logic [I_WIDTH-1:0]    pd   = iact_in_data;
    logic [CTRL_WIDTH-1:0] ectrl = '0;
    logic [I_WIDTH-1:0]    eiact = '0;
    logic [P_WIDTH-1:0]    capv;
    chain_off = chain_ramp ? P_WIDTH'(cyc * 5 + 7) : P_WIDTH'(7);
    capv = m_bias + chain_off;
    chk("iact_in_ready", {31'd0, iact_in_ready}, {31'd0, pre < DEPTH});
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !m_busy});
    @(posedge clk); #1; cyc++;
    if (beat) begin
      eiact = m_q.pop_front();
      ectrl = {m_cfg, (m_done == m_len - 1), (m_done == 0), 1'b1};
      if (m_done == m_len - 1) begin
        m_stream = 0; m_drain = 1; m_cap_edge = cyc + DRAIN_LAT;
      end
      m_done++;
    end
    if (push) m_q.push_back(pd);
    if (acc) begin
      m_busy = 1; m_len = int'(cmd_len); m_cfg = cmd_cfg; m_bias = cmd_bias; m_done = 0;
      if (cmd_len != 0) m_stream = 1;
      else begin m_drain = 1; m_cap_edge = cyc + DRAIN_LAT; end
    end
    if (cap) begin m_drain = 0; m_hold = 1; m_res = capv; end
    if (rel) begin m_hold = 0; m_busy = 0; end
    chk("sys_ctrl_out", 32'(sys_ctrl_out), 32'(ectrl));
    chk("sys_iact_out", 32'(sys_iact_out), 32'(eiact));
    chk("sys_psum_out", 32'(sys_psum_out), m_busy ? 32'(m_bias) : 32'd0);
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("res_valid", {31'd0, res_valid}, {31'd0, m_hold});
    if (m_hold) chk("res_data", 32'(res_data), 32'(m_res));
  endtask

  task automatic do_reset();
    iact_in_valid = 0; cmd_valid = 0; res_ready = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ctrl", 32'(sys_ctrl_out), 32'd0);
    chk("rst_iact", 32'(sys_iact_out), 32'd0);
    chk("rst_psum", 32'(sys_psum_out), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_iact_ready", {31'd0, iact_in_ready}, 32'd1);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1; cyc++;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic push1(input logic [I_WIDTH-1:0] v);
    iact_in_valid = 1; iact_in_data = v;
    step();
    iact_in_valid = 0;
  endtask

  // Issue one command and run until the model has consumed its result
  task automatic run_pass(input int len, input logic [CFG_W-1:0] cfg,
                          input logic [P_WIDTH-1:0] bias, input int push_every,
                          input int hold, input bit ramp);
    int hc = 0;
    chain_ramp = ramp;
    cmd_len = LEN_W'(len); cmd_cfg = cfg; cmd_bias = bias;
    cmd_valid = 1; iact_in_valid = 0; res_ready = 0;
    step();
    cmd_valid = 0;
    cmd_len = LEN_W'($urandom); cmd_cfg = CFG_W'($urandom); cmd_bias = P_WIDTH'($urandom);
    for (int k = 1; k < 400 && m_busy; k++) begin
      iact_in_valid = (push_every != 0) && (k % push_every == 0);
      iact_in_data  = I_WIDTH'($urandom);
      res_ready     = m_hold && (hc >= hold);
      if (m_hold) hc++;
      step();
    end
    iact_in_valid = 0; res_ready = 0;
  endtask

  initial begin
    model_clear();
    do_reset();
    step();

    // Preloaded burst with literal data and config
    push1(8'h11); push1(8'h22); push1(8'h33);
    run_pass(3, 6'h2A, P_WIDTH'($urandom), 0, 0, 0);

    // Empty FIFO, trickle-fed: bubbles between the two valid beats
    run_pass(2, 6'h15, P_WIDTH'($urandom), 3, 1, 0);

    // len = 1, bias 0x100, chain adds 7, result held 5 cycles
    push1(8'h5C);
    run_pass(1, 6'h01, 20'h00100, 0, 5, 0);

    // Fill FIFO past DEPTH, then stream with push and pop every cycle
    for (int i = 0; i < DEPTH + 2; i++) push1(I_WIDTH'($urandom));
    run_pass(DEPTH + 4, CFG_W'($urandom), P_WIDTH'($urandom), 1, 1, 1);

    // Zero-length command: no beats, result DRAIN_LAT cycles after accept
    run_pass(0, CFG_W'($urandom), P_WIDTH'($urandom), 2, 2, 1);

    // Randomized passes
    for (int p = 0; p < 6; p++) begin
      run_pass(int'($urandom_range(1, 12)), CFG_W'($urandom), P_WIDTH'($urandom),
               int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1);
      if ($urandom_range(0, 1) == 1) step();
    end

    // Reset in the middle of a len = 5 burst after two beats
    push1(8'hA1); push1(8'hA2);
    cmd_len = 8'd5; cmd_cfg = 6'h3F; cmd_bias = P_WIDTH'($urandom); cmd_valid = 1;
    step();
    cmd_valid = 0;
    step(); step();
    do_reset();
    run_pass(2, 6'h0C, P_WIDTH'($urandom), 3, 0, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
